// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port RAM with a
// registered read. Grants are combinational; responses come one cycle later
// and are decoded from a registered response tag.
module mem_arbiter #(
  parameter int MAX_D_RUN = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [31:0] mem_dout
);

  localparam int CW = (MAX_D_RUN < 1) ? 1 : $clog2(MAX_D_RUN + 1);

  typedef enum logic [2:0] {
    TAG_NONE, TAG_F_RD, TAG_F_ERR, TAG_D_RD, TAG_D_WR, TAG_D_ERR
  } tag_t;

  tag_t          tag;
  logic [CW-1:0] run_cnt;
  logic          run_full, d_win, if_ok, d_ok;

  // Arbitration and RAM request steering; data wins unless its run is spent.
  always_comb begin
    run_full = (run_cnt == CW'(MAX_D_RUN));
    if_ok    = (if_addr[1:0] == 2'b00);
    d_ok     = (d_addr[1:0] == 2'b00);
    d_win    = d_req && !(if_req && run_full);
    d_gnt    = resetn && d_win;
    if_gnt   = resetn && if_req && !d_win;
    mem_addr = d_gnt ? d_addr[31:2] : if_addr[31:2];
    mem_din  = d_wdata;
    mem_re   = (if_gnt && if_ok) || (d_gnt && d_ok && !d_we);
    mem_we   = d_gnt && d_ok && d_we;
  end

  // Response tag: records what the current grant must answer next cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     tag <= TAG_NONE;
    else if (d_gnt)  tag <= !d_ok ? TAG_D_ERR : (d_we ? TAG_D_WR : TAG_D_RD);
    else if (if_gnt) tag <= if_ok ? TAG_F_RD : TAG_F_ERR;
    else             tag <= TAG_NONE;
  end

  // Consecutive data grants while fetch waits; any fetch grant or idle fetch clears.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                     run_cnt <= '0;
    else if (!if_req || if_gnt)      run_cnt <= '0;
    else if (d_gnt && !run_full)     run_cnt <= run_cnt + CW'(1);
  end

  assign if_rvalid = (tag == TAG_F_RD) || (tag == TAG_F_ERR);
  assign if_err    = (tag == TAG_F_ERR);
  assign if_rdata  = mem_dout;
  assign d_rvalid  = (tag == TAG_D_RD) || (tag == TAG_D_WR) || (tag == TAG_D_ERR);
  assign d_err     = (tag == TAG_D_ERR);
  assign d_rdata   = mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, reset corner sequences and a
// randomized run, all checked against a transaction-level model.
module tb_mem_arbiter;
  localparam int MAX = 3;

  logic        clk, resetn;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [29:0] mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic        mem_re, mem_we;

  int checks = 0, errors = 0;
  int streak = 0;
  logic [31:0] shadow [16];
  logic [31:0] ram [16];

  mem_arbiter #(.MAX_D_RUN(MAX)) dut (
    .clk(clk), .resetn(resetn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_re(mem_re), .mem_we(mem_we),
    .mem_dout(mem_dout)
  );

  initial begin clk = 0; forever #5 clk = ~clk; end

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0101_0111;
  endfunction

  // Registered-read RAM: 16 words, refilled while reset is held.
  always @(posedge clk) begin
    if (!resetn) for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
    else if (mem_we) ram[mem_addr[3:0]] <= mem_din;
    if (mem_re) mem_dout <= ram[mem_addr[3:0]];
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s: got %b expected %b", nm, act, exp); end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s: got %h expected %h", nm, act, exp); end
  endtask

  task automatic model_reset();
    streak = 0;
    for (int i = 0; i < 16; i++) shadow[i] = init_word(i);
  endtask

  // One cycle: drive, check grants/RAM controls, then check the response.
  task automatic step(input logic ifr, input logic [31:0] ifa, input logic dr,
                      input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                      output logic g_if, output logic g_d);
    logic e_if, e_d, ia, da_ok, e_re, e_we;
    logic [31:0] e_ifdata, e_ddata;
    @(negedge clk);
    if_req = ifr; if_addr = ifa; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    #1;
    e_d   = dr && !(ifr && streak >= MAX);
    e_if  = ifr && !e_d;
    ia    = (ifa % 4) == 0;
    da_ok = (da % 4) == 0;
    e_re  = (e_if && ia) || (e_d && !dwe && da_ok);
    e_we  = e_d && dwe && da_ok;
    g_if = if_gnt; g_d = d_gnt;
    chk1("if_gnt", if_gnt, e_if);
    chk1("d_gnt", d_gnt, e_d);
    chk1("mem_re", mem_re, e_re);
    chk1("mem_we", mem_we, e_we);
    if (e_re || e_we) chk32("mem_addr", {2'b00, mem_addr}, (e_d ? da : ifa) / 4);
    if (e_we) chk32("mem_din", mem_din, dwd);
    e_ifdata = shadow[(ifa / 4) % 16];
    e_ddata  = shadow[(da / 4) % 16];
    if (e_we) shadow[(da / 4) % 16] = dwd;
    if (!ifr || e_if) streak = 0;
    else if (e_d && streak < MAX) streak = streak + 1;
    @(posedge clk); #1;
    chk1("if_rvalid", if_rvalid, e_if);
    chk1("if_err", if_err, e_if && !ia);
    if (e_if && ia) chk32("if_rdata", if_rdata, e_ifdata);
    chk1("d_rvalid", d_rvalid, e_d);
    chk1("d_err", d_err, e_d && !da_ok);
    if (e_d && !dwe && da_ok) chk32("d_rdata", d_rdata, e_ddata);
  endtask

  // Hold reset a few cycles with both ports requesting; everything must stay quiet.
  task automatic do_reset();
    @(negedge clk);
    resetn = 0; if_req = 1; d_req = 1; d_we = 1; if_addr = 0; d_addr = 0;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk1("rst_if_gnt", if_gnt, 1'b0); chk1("rst_d_gnt", d_gnt, 1'b0);
      chk1("rst_mem_re", mem_re, 1'b0); chk1("rst_mem_we", mem_we, 1'b0);
      chk1("rst_if_rvalid", if_rvalid, 1'b0); chk1("rst_d_rvalid", d_rvalid, 1'b0);
      chk1("rst_if_err", if_err, 1'b0); chk1("rst_d_err", d_err, 1'b0);
      @(negedge clk); #1;
    end
    model_reset();
    if_req = 0; d_req = 0; d_we = 0;
    resetn = 1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 15)) * 4;
    if ($urandom_range(0, 4) == 0) a = a + 32'($urandom_range(1, 3));
    return a;
  endfunction

  typedef struct {
    logic ifr; logic [31:0] ifa; logic dr; logic dwe;
    logic [31:0] da; logic [31:0] dwd; logic eif; logic ed;
  } vec_t;
  vec_t tbl [15];

  initial begin
    logic gi, gd;
    logic cur_ifr, cur_dr, cur_we;
    logic [31:0] cur_ifa, cur_da, cur_wd;
    resetn = 0; if_req = 0; d_req = 0; d_we = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0;

    tbl[0]  = '{1, 32'h0,  0, 0, 32'h0,  32'h0, 1, 0};
    tbl[1]  = '{1, 32'h4,  0, 0, 32'h0,  32'h0, 1, 0};
    tbl[2]  = '{1, 32'h8,  0, 0, 32'h0,  32'h0, 1, 0};
    tbl[3]  = '{0, 32'h0,  1, 1, 32'h10, 32'hDEADBEEF, 0, 1};
    tbl[4]  = '{0, 32'h0,  1, 0, 32'h10, 32'h0, 0, 1};
    for (int i = 5; i < 13; i++)
      tbl[i] = '{1, 32'hC, 1, 0, 32'h14, 32'h0, ((i - 5) % 4) == 3, ((i - 5) % 4) != 3};
    tbl[13] = '{0, 32'h0,  1, 0, 32'h13, 32'h0, 0, 1};
    tbl[14] = '{0, 32'h0,  0, 0, 32'h0,  32'h0, 0, 0};

    do_reset();

    // Directed vectors: fetch stream, write/read-back, D,D,D,F, misaligned read.
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].ifr, tbl[i].ifa, tbl[i].dr, tbl[i].dwe, tbl[i].da, tbl[i].dwd, gi, gd);
      chk1($sformatf("tbl%0d_if_gnt", i), gi, tbl[i].eif);
      chk1($sformatf("tbl%0d_d_gnt", i), gd, tbl[i].ed);
    end
    chk32("rb_deadbeef", shadow[4], 32'hDEADBEEF);

    // Reset early in the response cycle of a fetch grant kills the response.
    @(negedge clk);
    if_req = 1; if_addr = 32'h8; d_req = 0;
    #1 chk1("pre_rst_if_gnt", if_gnt, 1'b1);
    @(posedge clk); #1;
    resetn = 0;
    #1 chk1("rst_kills_rvalid", if_rvalid, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      chk1("rst_rvalid_stays0", if_rvalid, 1'b0);
      chk1("rst_if_gnt_held", if_gnt, 1'b0);
    end
    model_reset();
    if_req = 0;
    @(negedge clk); resetn = 1;
    step(0, 0, 0, 0, 0, 0, gi, gd);
    chk1("post_rst_no_resp", gi | gd, 1'b0);

    // Build a partial data run, reset, and expect a full run of MAX data grants.
    step(1, 32'h20, 1, 0, 32'h24, 0, gi, gd);
    step(1, 32'h20, 1, 0, 32'h24, 0, gi, gd);
    do_reset();
    for (int i = 0; i <= MAX; i++) begin
      step(1, 32'h20, 1, 0, 32'h24, 0, gi, gd);
      chk1($sformatf("post_rst_run%0d_d", i), gd, i < MAX);
    end

    // Randomized traffic; requests stay stable until granted.
    cur_ifr = 0; cur_dr = 0; cur_we = 0; cur_ifa = 0; cur_da = 0; cur_wd = 0;
    for (int n = 0; n < 400; n++) begin
      if (!cur_ifr && $urandom_range(0, 3) != 0) begin cur_ifr = 1; cur_ifa = rand_addr(); end
      if (!cur_dr && $urandom_range(0, 2) != 0) begin
        cur_dr = 1; cur_da = rand_addr(); cur_we = 1'($urandom_range(0, 1)); cur_wd = $urandom;
      end
      step(cur_ifr, cur_ifa, cur_dr, cur_we, cur_da, cur_wd, gi, gd);
      if (gi) cur_ifr = 0;
      if (gd) cur_dr = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
